// File: rtl/k_and_s_pkg.sv
// Shared K-and-S types and constants used by the RAM arbiter.
package k_and_s_pkg;

  // Upper bound on the RAM read latency the arbiter can sequence.
  localparam int unsigned ARB_MAX_LAT = 4;
  localparam int unsigned ARB_LAT_W   = $clog2(ARB_MAX_LAT + 1);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_CORE,
    OWN_LOADER
  } owner_t;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter with zero flag; times the WAIT phase of the arbiter.
module arb_lat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the shared K-and-S program/data RAM (core C, loader L).
// Access sequence: IDLE -> GRANT (1 cycle, RAM write strobe) -> WAIT (RAM_LAT
// cycles, done pulse in the last one) -> IDLE.
// Build option: define KS_ARB_CORE_PRIO_EN for fixed core priority on ties;
// otherwise ties alternate round-robin.
module ram_arbiter
  import k_and_s_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_done,
  input  logic              l_lock,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if ((RAM_LAT < 1) || (RAM_LAT > ARB_MAX_LAT)) begin : g_bad_lat
    $error("ram_arbiter: RAM_LAT must be in 1..%0d", ARB_MAX_LAT);
  end

  localparam logic [ARB_LAT_W-1:0] LAT_LOAD = ARB_LAT_W'(RAM_LAT - 1);

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                we_q, we_d;
  logic                ram_we_q, ram_we_d;
  logic                c_gnt_q, c_gnt_d, l_gnt_q, l_gnt_d;
  logic                c_done_q, c_done_d, l_done_q, l_done_d;
  logic                fin_d, fin_q;
  logic                c_elig, l_elig, pick_core;
  logic                lat_load, lat_dec, lat_zero;
  logic [ARB_LAT_W-1:0] lat_count;

  arb_lat_counter #(
    .W (ARB_LAT_W)
  ) u_lat (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lat_load),
    .load_val_i (LAT_LOAD),
    .dec_i      (lat_dec),
    .count_o    (lat_count),
    .zero_o     (lat_zero)
  );

  // Eligibility and tie-break; owner_q doubles as last_owner for round-robin.
  always_comb begin
    c_elig = c_req & ~l_lock;
    l_elig = l_req;
`ifdef KS_ARB_CORE_PRIO_EN
    pick_core = c_elig;
`else
    pick_core = c_elig & (~l_elig | (owner_q == OWN_LOADER));
`endif
  end

  // Next-state, request latch and registered pulse generation.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    ram_we_d = 1'b0;
    c_gnt_d  = 1'b0;
    l_gnt_d  = 1'b0;
    fin_d    = 1'b0;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    rdata_d  = rdata_q;
    if (fin_q && !we_q) begin
      rdata_d = ram_rdata;
    end
    unique case (state_q)
      ARB_IDLE: begin
        if (c_elig || l_elig) begin
          state_d = ARB_GRANT;
          if (pick_core) begin
            owner_d = OWN_CORE;
            addr_d  = c_addr;
            wdata_d = c_wdata;
            we_d    = c_we;
            c_gnt_d = 1'b1;
          end else begin
            owner_d = OWN_LOADER;
            addr_d  = l_addr;
            wdata_d = l_wdata;
            we_d    = l_we;
            l_gnt_d = 1'b1;
          end
          ram_we_d = we_d;
        end
      end
      ARB_GRANT: begin
        state_d  = ARB_WAIT;
        lat_load = 1'b1;
        fin_d    = (RAM_LAT == 1);
      end
      ARB_WAIT: begin
        if (lat_zero) begin
          state_d = ARB_IDLE;
        end else begin
          lat_dec = 1'b1;
          fin_d   = (lat_count == ARB_LAT_W'(1));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    c_done_d = fin_d & (owner_q == OWN_CORE);
    l_done_d = fin_d & (owner_q == OWN_LOADER);
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_LOADER;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      ram_we_q <= 1'b0;
      c_gnt_q  <= 1'b0;
      l_gnt_q  <= 1'b0;
      c_done_q <= 1'b0;
      l_done_q <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      ram_we_q <= ram_we_d;
      c_gnt_q  <= c_gnt_d;
      l_gnt_q  <= l_gnt_d;
      c_done_q <= c_done_d;
      l_done_q <= l_done_d;
      fin_q    <= fin_d;
    end
  end

  // RAM data lands in the done cycle itself, so a read forwards it there and
  // the register only supplies the held value between accesses.
  assign rdata     = (fin_q && !we_q) ? ram_rdata : rdata_q;
  assign c_gnt     = c_gnt_q;
  assign l_gnt     = l_gnt_q;
  assign c_done    = c_done_q;
  assign l_done    = l_done_q;
  assign ram_addr  = addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = wdata_q;

endmodule
